// File: rtl/systemx_share_codec_if.sv
// Handshake and share bus between the plaintext codec and its neighbours:
// plaintext request in, masked shares/randomness to the core, result out.
interface systemx_share_codec_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_a;
    logic        in_b;
    logic        in_c;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        A0;
    logic        A1;
    logic        B0;
    logic        B1;
    logic        C0;
    logic        C1;
    logic [7:0]  r;
    logic        F0;
    logic        F1;
    logic        out_valid;
    logic        out_ready;
    logic        out_f;
    logic [15:0] txn_count;

    // Codec side
    modport slave (
        input  in_valid, in_a, in_b, in_c, seed_load, seed_in, F0, F1, out_ready,
        output in_ready, A0, A1, B0, B1, C0, C1, r, out_valid, out_f, txn_count
    );

    // Environment side (requester, core and result consumer)
    modport master (
        output in_valid, in_a, in_b, in_c, seed_load, seed_in, F0, F1, out_ready,
        input  in_ready, A0, A1, B0, B1, C0, C1, r, out_valid, out_f, txn_count
    );
endinterface

// File: rtl/systemx_share_codec.sv
// Plaintext front/back end for the 2-share masked SystemX core: splits a
// plaintext triple into Boolean shares with an LFSR mask, feeds fresh
// randomness, waits the core latency and returns F0^F1 over valid/ready.
module systemx_share_codec #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int unsigned CORE_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    systemx_share_codec_if.slave   bus
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  LAT      = 4'(CORE_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [3:0]  cnt;

    // Galois right-shift step, taps 16'hB400
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) begin
            n = n ^ 16'hB400;
        end
        return n;
    endfunction

    // Requests are only taken in IDLE, and never while a reseed is pending
    assign bus.in_ready = (state == IDLE) && !bus.seed_load;

    // Transaction FSM with all shares, randomness and result registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            cnt           <= '0;
            bus.A0        <= 1'b0;
            bus.A1        <= 1'b0;
            bus.B0        <= 1'b0;
            bus.B1        <= 1'b0;
            bus.C0        <= 1'b0;
            bus.C1        <= 1'b0;
            bus.r         <= '0;
            bus.out_f     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.seed_load) begin
                        lfsr <= (bus.seed_in == 16'h0000) ? 16'h0001 : bus.seed_in;
                    end else if (bus.in_valid) begin
                        bus.A0 <= lfsr[0];
                        bus.A1 <= bus.in_a ^ lfsr[0];
                        bus.B0 <= lfsr[1];
                        bus.B1 <= bus.in_b ^ lfsr[1];
                        bus.C0 <= lfsr[2];
                        bus.C1 <= bus.in_c ^ lfsr[2];
                        bus.r  <= lfsr[10:3];
                        lfsr   <= lfsr_step(lfsr);
                        cnt    <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        bus.out_f     <= bus.F0 ^ bus.F1;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.txn_count <= bus.txn_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systemx_share_codec.sv
// Directed bench for systemx_share_codec with a one-cycle-latency masked
// core model built from the registered shares.
module tb_systemx_share_codec;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    systemx_share_codec_if bus ();

    systemx_share_codec #(
        .SEED         (16'hACE1),
        .CORE_LATENCY (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference unmasked function implemented by the core model
    function automatic logic ref_f(input logic a, input logic b, input logic c);
        return (a & b) ^ c;
    endfunction

    // Independent LFSR model
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] t;
        t = {1'b0, s[15:1]};
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    // Core model: one register stage on the shares, output shares masked by r[1]
    logic [5:0] core_sh;
    logic [7:0] core_r;
    always_ff @(posedge clk) begin
        core_sh <= {bus.A0, bus.A1, bus.B0, bus.B1, bus.C0, bus.C1};
        core_r  <= bus.r;
    end
    assign bus.F0 = core_sh[5] ^ core_r[1];
    assign bus.F1 = bus.F0 ^ ref_f(core_sh[5] ^ core_sh[4],
                                   core_sh[3] ^ core_sh[2],
                                   core_sh[1] ^ core_sh[0]);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !bus.out_valid; k++) tick();
        chk(tag, 16'(bus.out_valid), 16'd1);
    endtask

    task automatic chk_shares(input string tag, input logic [5:0] exp);
        chk(tag, 16'({bus.A0, bus.A1, bus.B0, bus.B1, bus.C0, bus.C1}), 16'(exp));
    endtask

    initial begin
        logic [15:0] lm;
        logic [2:0]  v;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b0;
        bus.in_c      = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out_f", 16'(bus.out_f), 16'd0);
        chk_shares("rst_shares", 6'b000000);
        chk("rst_r", 16'(bus.r), 16'h0000);
        chk("rst_txn", bus.txn_count, 16'h0000);

        // First request (1,0,1) with mask from lfsr 16'hACE1
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0; bus.in_c = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_shares("t1_shares", 6'b100001);
        chk("t1_r", 16'(bus.r), 16'h009C);
        chk("t1_in_ready", 16'(bus.in_ready), 16'd0);
        chk("t1_valid_e1", 16'(bus.out_valid), 16'd0);
        tick();
        chk("t1_valid_e1b", 16'(bus.out_valid), 16'd0);
        tick();
        chk("t1_valid_e2", 16'(bus.out_valid), 16'd1);
        chk("t1_out_f", 16'(bus.out_f), 16'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_valid_drop", 16'(bus.out_valid), 16'd0);
        chk("t1_txn", bus.txn_count, 16'd1);
        chk("t1_in_ready", 16'(bus.in_ready), 16'd1);

        // Second request (0,1,1): lfsr 16'hE270 gives zero masks
        bus.in_valid = 1'b1; bus.in_a = 1'b0; bus.in_b = 1'b1; bus.in_c = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_shares("t2_shares", 6'b000101);
        chk("t2_r", 16'(bus.r), 16'h004E);
        wait_valid("t2_valid");
        chk("t2_out_f", 16'(bus.out_f), 16'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_txn", bus.txn_count, 16'd2);

        // Sweep of all triples from a fresh reset, out_ready held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        lm = 16'hACE1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            bus.in_valid = 1'b1; bus.in_a = v[2]; bus.in_b = v[1]; bus.in_c = v[0];
            tick();
            bus.in_valid = 1'b0;
            chk("sw_a", 16'(bus.A0 ^ bus.A1), 16'(v[2]));
            chk("sw_b", 16'(bus.B0 ^ bus.B1), 16'(v[1]));
            chk("sw_c", 16'(bus.C0 ^ bus.C1), 16'(v[0]));
            chk("sw_mask", 16'({bus.A0, bus.B0, bus.C0}), 16'({lm[0], lm[1], lm[2]}));
            chk("sw_r", 16'(bus.r), 16'(lm[10:3]));
            wait_valid("sw_valid");
            chk("sw_out_f", 16'(bus.out_f), 16'(ref_f(v[2], v[1], v[0])));
            tick();
            chk("sw_hs", 16'(bus.out_valid), 16'd0);
            lm = model_step(lm);
        end
        chk("sw_txn", bus.txn_count, 16'd8);
        bus.out_ready = 1'b0;

        // Backpressure in OUT: result held, no further acceptance
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1; bus.in_c = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_a", 16'(bus.A0 ^ bus.A1), 16'd1);
        chk("bp_r", 16'(bus.r), 16'(lm[10:3]));
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 1'b0; bus.in_b = 1'b0; bus.in_c = 1'b1;
            #1;
            chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
            tick();
            chk("bp_hold_valid", 16'(bus.out_valid), 16'd1);
            chk("bp_hold_f", 16'(bus.out_f), 16'd1);
            chk("bp_hold_a", 16'(bus.A0 ^ bus.A1), 16'd1);
            chk("bp_hold_r", 16'(bus.r), 16'(lm[10:3]));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release", 16'(bus.out_valid), 16'd0);
        chk("bp_idle", 16'(bus.in_ready), 16'd1);
        chk("bp_txn", bus.txn_count, 16'd9);

        // Reseed with 0 concurrent with a request
        bus.seed_load = 1'b1; bus.seed_in = 16'h0000;
        bus.in_valid = 1'b1; bus.in_a = 1'b0; bus.in_b = 1'b0; bus.in_c = 1'b0;
        #1;
        chk("sl_in_ready", 16'(bus.in_ready), 16'd0);
        tick();
        chk("sl_not_taken", 16'(bus.in_ready), 16'd0);
        bus.seed_load = 1'b0;
        #1;
        chk("sl_ready_next", 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_shares("sl_shares", 6'b110000);
        chk("sl_r", 16'(bus.r), 16'h0000);
        wait_valid("sl_valid");
        chk("sl_out_f", 16'(bus.out_f), 16'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("sl_txn", bus.txn_count, 16'd10);

        // Asynchronous reset during WAIT
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b1; bus.in_c = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 16'(bus.out_valid), 16'd0);
        chk_shares("ar_shares", 6'b000000);
        chk("ar_r", 16'(bus.r), 16'h0000);
        chk("ar_txn", bus.txn_count, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0; bus.in_c = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_shares("ar_seed_shares", 6'b100001);
        chk("ar_seed_r", 16'(bus.r), 16'h009C);
        wait_valid("ar_valid2");
        chk("ar_out_f", 16'(bus.out_f), 16'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ar_txn2", bus.txn_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
